spi_rdid_responder: RTL and testbench

Synthesizable SPI mode-0 flash responder that answers the RDID (0x9F) and RDSR (0x05) commands with fixed identification bytes and a live status byte. It is the target end of the flash-ID link: it sits on the FPGA side of an SPI bus so the SPI master can be exercised and verified in hardware without a physical flash. All SPI pins are oversampled in the `clk` domain; no logic is clocked by `spi_clk`.

---
 rtl/spi_rdid_responder_if.sv | 23 ++
 rtl/spi_rdid_responder.sv | 190 +++++++++++++++++++
 tb/tb_spi_rdid_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_rdid_responder_if.sv
// SPI pin bundle plus command-decode sideband for the RDID/RDSR flash responder.
// The master modport is the SPI master / checker side; the slave modport is the responder.
interface spi_rdid_responder_if;
  logic       spi_clk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic [7:0] status_reg;
  logic       spi_miso;
  logic       busy;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       cmd_unsupported;

  modport master (
    output spi_clk, spi_cs_n, spi_mosi, status_reg,
    input  spi_miso, busy, cmd_valid, cmd_byte, cmd_unsupported
  );

  modport slave (
    input  spi_clk, spi_cs_n, spi_mosi, status_reg,
    output spi_miso, busy, cmd_valid, cmd_byte, cmd_unsupported
  );
endinterface

// File: rtl/spi_rdid_responder.sv
// SPI mode-0 flash stand-in answering RDID (0x9F) and RDSR (0x05); every SPI pin
// is oversampled in the clk domain, nothing is clocked by spi_clk.
module spi_rdid_responder #(
  parameter logic [7:0] MANUFACTURER_ID = 8'h20,
  parameter logic [7:0] MEMORY_TYPE     = 8'h20,
  parameter logic [7:0] MEMORY_CAPACITY = 8'h15
) (
  input  logic               clk,
  input  logic               reset,
  spi_rdid_responder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CMD, TX_ID, TX_SR, IGNORE} state_e;

  state_e      state_q, state_d;

  logic [2:0]  sclk_q;
  logic [2:0]  cs_q;
  logic [1:0]  mosi_q;
  logic        armed_q;

  logic [2:0]  bit_cnt_q;
  logic [7:0]  cmd_sr_q;
  logic [7:0]  cmd_byte_q;
  logic [4:0]  tx_cnt_q;
  logic [23:0] id_sr_q;
  logic [7:0]  sr_sr_q;
  logic [7:0]  status_hold_q;
  logic        miso_q;
  logic        busy_q;
  logic        cmd_valid_q;
  logic        unsup_q;

  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [7:0]  cmd_shift;

  logic        abort, clr_cmd, shift_cmd, cmd_done;
  logic        ld_id, ld_sr, unsup, drive_id, drive_sr;

  // Stage [1] is the synchronized level, stage [2] the delayed copy for edge detect.
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cmd_shift = {cmd_sr_q[6:0], mosi_q[1]};

  // CS synchronizer resets low so a CS already low at reset release never
  // looks like a fresh falling edge; armed_q keeps busy quiet until CS is seen high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q  <= '0;
      cs_q    <= '0;
      mosi_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.spi_clk};
      cs_q   <= {cs_q[1:0], bus.spi_cs_n};
      mosi_q <= {mosi_q[0], bus.spi_mosi};
      if (cs_q[2]) armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort)         state_d = IDLE;
    else if (clr_cmd)  state_d = CMD;
    else if (ld_id)    state_d = TX_ID;
    else if (ld_sr)    state_d = TX_SR;
    else if (unsup)    state_d = IGNORE;
  end

  always_comb begin
    abort     = 1'b0;
    clr_cmd   = 1'b0;
    shift_cmd = 1'b0;
    cmd_done  = 1'b0;
    ld_id     = 1'b0;
    ld_sr     = 1'b0;
    unsup     = 1'b0;
    drive_id  = 1'b0;
    drive_sr  = 1'b0;
    if (cs_rise) begin
      abort = 1'b1;
    end else begin
      unique case (state_q)
        IDLE:  clr_cmd = cs_fall;
        CMD: begin
          if (sclk_rise) begin
            shift_cmd = 1'b1;
            if (bit_cnt_q == 3'd7) begin
              cmd_done = 1'b1;
              case (cmd_shift)
                8'h9F:   ld_id = 1'b1;
                8'h05:   ld_sr = 1'b1;
                default: unsup = 1'b1;
              endcase
            end
          end
        end
        TX_ID:  drive_id = sclk_fall;
        TX_SR:  drive_sr = sclk_fall;
        IGNORE: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q     <= '0;
      cmd_sr_q      <= '0;
      cmd_byte_q    <= '0;
      tx_cnt_q      <= '0;
      id_sr_q       <= '0;
      sr_sr_q       <= '0;
      status_hold_q <= '0;
      miso_q        <= 1'b0;
      busy_q        <= 1'b0;
      cmd_valid_q   <= 1'b0;
      unsup_q       <= 1'b0;
    end else begin
      cmd_valid_q <= cmd_done;
      unsup_q     <= unsup;
      busy_q      <= armed_q & ~cs_q[2];

      if (abort) begin
        miso_q    <= 1'b0;
        bit_cnt_q <= '0;
        tx_cnt_q  <= '0;
      end

      if (clr_cmd) begin
        bit_cnt_q <= '0;
        cmd_sr_q  <= '0;
      end

      if (shift_cmd) begin
        cmd_sr_q  <= cmd_shift;
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end

      if (cmd_done) begin
        cmd_byte_q <= cmd_shift;
        tx_cnt_q   <= '0;
      end

      if (ld_id) id_sr_q <= {MANUFACTURER_ID, MEMORY_TYPE, MEMORY_CAPACITY};

      if (ld_sr) begin
        sr_sr_q       <= bus.status_reg;
        status_hold_q <= bus.status_reg;
      end

      // ID stream stops at 24 bits and then reads zero; no wrap.
      if (drive_id) begin
        if (tx_cnt_q != 5'd24) begin
          miso_q   <= id_sr_q[23];
          id_sr_q  <= {id_sr_q[22:0], 1'b0};
          tx_cnt_q <= tx_cnt_q + 5'd1;
        end else begin
          miso_q <= 1'b0;
        end
      end

      // Status stream repeats the byte sampled at decode for as long as CS stays low.
      if (drive_sr) begin
        miso_q <= sr_sr_q[7];
        if (tx_cnt_q[2:0] == 3'd7) begin
          sr_sr_q  <= status_hold_q;
          tx_cnt_q <= '0;
        end else begin
          sr_sr_q  <= {sr_sr_q[6:0], 1'b0};
          tx_cnt_q <= tx_cnt_q + 5'd1;
        end
      end
    end
  end

  assign bus.spi_miso        = miso_q;
  assign bus.busy            = busy_q;
  assign bus.cmd_valid       = cmd_valid_q;
  assign bus.cmd_byte        = cmd_byte_q;
  assign bus.cmd_unsupported = unsup_q;

endmodule

// File: tb/tb_spi_rdid_responder.sv
// Directed bench for spi_rdid_responder: bit-banged SPI mode-0 master with
// hand-computed expected bytes, checked by immediate assertions.
module tb_spi_rdid_responder;

  localparam int HALF = 6;

  logic clk;
  logic reset;

  spi_rdid_responder_if bus ();

  spi_rdid_responder #(
    .MANUFACTURER_ID (8'h20),
    .MEMORY_TYPE     (8'h20),
    .MEMORY_CAPACITY (8'h15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int cv_cnt = 0;
  int un_cnt = 0;
  int hi_cnt = 0;

  always @(posedge clk) begin
    if (bus.cmd_valid === 1'b1)       cv_cnt++;
    if (bus.cmd_unsupported === 1'b1) un_cnt++;
    if (bus.spi_miso === 1'b1)        hi_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer_bit(input logic mo, output logic mi);
    bus.spi_mosi = mo;
    wait_clk(HALF);
    bus.spi_clk = 1'b1;
    mi = bus.spi_miso;
    wait_clk(HALF);
    bus.spi_clk = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] mo, output logic [7:0] mi);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(mo[i], b);
      mi[i] = b;
    end
  endtask

  task automatic cs_low();
    bus.spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    bus.spi_cs_n = 1'b1;
    wait_clk(10);
  endtask

  task automatic rdid_full(input string tag);
    logic [7:0] r;
    int cv0;
    cv0 = cv_cnt;
    cs_low();
    xfer_byte(8'h9F, r);
    xfer_byte(8'h00, r); chk({tag, "_b0"}, r, 8'h20);
    xfer_byte(8'h00, r); chk({tag, "_b1"}, r, 8'h20);
    xfer_byte(8'h00, r); chk({tag, "_b2"}, r, 8'h15);
    chk({tag, "_cv"}, cv_cnt - cv0, 1);
    cs_high();
  endtask

  logic [7:0] r;
  logic       b;
  int         cv0, un0, hi0;

  initial begin
    reset          = 1'b1;
    bus.spi_clk    = 1'b0;
    bus.spi_cs_n   = 1'b1;
    bus.spi_mosi   = 1'b0;
    bus.status_reg = 8'h00;
    wait_clk(4);
    chk("rst_miso",  bus.spi_miso, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_cv",    bus.cmd_valid, 0);
    chk("rst_unsup", bus.cmd_unsupported, 0);
    chk("rst_cmd",   bus.cmd_byte, 8'h00);
    reset = 1'b0;
    wait_clk(10);

    // RDID
    cv0 = cv_cnt; un0 = un_cnt;
    cs_low();
    chk("rdid_busy", bus.busy, 1);
    xfer_byte(8'h9F, r); chk("rdid_cmdphase_miso", r, 8'h00);
    xfer_byte(8'h00, r); chk("rdid_b0", r, 8'h20);
    xfer_byte(8'h00, r); chk("rdid_b1", r, 8'h20);
    xfer_byte(8'h00, r); chk("rdid_b2", r, 8'h15);
    chk("rdid_cv_once", cv_cnt - cv0, 1);
    chk("rdid_cmd_byte", bus.cmd_byte, 8'h9F);
    chk("rdid_unsup", un_cnt - un0, 0);
    cs_high();
    chk("rdid_busy_off", bus.busy, 0);
    chk("rdid_miso_idle", bus.spi_miso, 0);

    // RDSR wrap, status change mid-transfer ignored
    bus.status_reg = 8'hA5;
    cs_low();
    xfer_byte(8'h05, r);
    xfer_byte(8'h00, r); chk("rdsr_b0", r, 8'hA5);
    bus.status_reg = 8'h3C;
    xfer_byte(8'h00, r); chk("rdsr_b1", r, 8'hA5);
    xfer_byte(8'h00, r); chk("rdsr_b2", r, 8'hA5);
    chk("rdsr_cmd_byte", bus.cmd_byte, 8'h05);
    cs_high();
    cs_low();
    xfer_byte(8'h05, r);
    xfer_byte(8'h00, r); chk("rdsr_new_status", r, 8'h3C);
    cs_high();

    // Unsupported command
    cv0 = cv_cnt; un0 = un_cnt; hi0 = hi_cnt;
    cs_low();
    xfer_byte(8'h03, r);
    xfer_byte(8'h00, r); chk("unsup_b0", r, 8'h00);
    xfer_byte(8'h00, r); chk("unsup_b1", r, 8'h00);
    chk("unsup_cv", cv_cnt - cv0, 1);
    chk("unsup_pulse", un_cnt - un0, 1);
    chk("unsup_cmd_byte", bus.cmd_byte, 8'h03);
    chk("unsup_miso_low", hi_cnt - hi0, 0);
    cs_high();

    // Abort after 5 command bits
    cv0 = cv_cnt;
    cs_low();
    xfer_bit(1'b1, b); xfer_bit(1'b0, b); xfer_bit(1'b0, b);
    xfer_bit(1'b1, b); xfer_bit(1'b1, b);
    cs_high();
    chk("abort_no_cv", cv_cnt - cv0, 0);
    chk("abort_cmd_held", bus.cmd_byte, 8'h03);
    rdid_full("post_abort");

    // Abort after 10 RDID data bits: bit index 10 of 0x202015 is 1
    cs_low();
    xfer_byte(8'h9F, r);
    for (int i = 0; i < 10; i++) xfer_bit(1'b0, b);
    wait_clk(HALF);
    chk("abort_tx_miso_hi", bus.spi_miso, 1);
    bus.spi_cs_n = 1'b1;
    wait_clk(4);
    chk("abort_tx_miso_low", bus.spi_miso, 0);
    wait_clk(10);

    // RDID past end
    cs_low();
    xfer_byte(8'h9F, r);
    xfer_byte(8'h00, r); chk("past_b0", r, 8'h20);
    xfer_byte(8'h00, r); chk("past_b1", r, 8'h20);
    xfer_byte(8'h00, r); chk("past_b2", r, 8'h15);
    xfer_byte(8'h00, r); chk("past_b3", r, 8'h00);
    cs_high();

    // Reset mid-RDID with CS held low
    cs_low();
    xfer_byte(8'h9F, r);
    for (int i = 0; i < 12; i++) xfer_bit(1'b0, b);
    wait_clk(2);
    reset = 1'b1;
    #1;
    chk("mid_rst_miso",  bus.spi_miso, 0);
    chk("mid_rst_busy",  bus.busy, 0);
    chk("mid_rst_cv",    bus.cmd_valid, 0);
    chk("mid_rst_unsup", bus.cmd_unsupported, 0);
    chk("mid_rst_cmd",   bus.cmd_byte, 8'h00);
    wait_clk(3);
    reset = 1'b0;
    wait_clk(10);
    chk("post_rst_busy", bus.busy, 0);
    cv0 = cv_cnt;
    xfer_byte(8'h9F, r);
    xfer_byte(8'h00, r);
    chk("post_rst_ignored_miso", r, 8'h00);
    chk("post_rst_no_cv", cv_cnt - cv0, 0);
    cs_high();
    rdid_full("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
